// File: rtl/verdma.sv
// rtl/verdma.sv - single-channel word-copy DMA engine with Verbus register and initiator ports
// Optional feature macro: VERDMA_ABORT_EN (software abort of an in-flight copy).
module verdma (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_address,
  input  logic [3:0]  cfg_wstrobe,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_ready,
  output logic        irq,
  output logic        m_valid,
  output logic [31:0] m_address,
  output logic [3:0]  m_wstrobe,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state, state_next;
  logic [31:0] src, dst, count, buffer;
  logic        irq_enable, done;
  logic [2:0]  reg_sel;
  logic        wr_en, ctrl_wr, busy, hs;
  logic        start_go, start_empty, abort_hit, abort_rd;
  logic        done_set, done_clr;
  logic        unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

  assign reg_sel     = cfg_address[4:2];
  assign unused_addr = ^{cfg_address[31:5], cfg_address[1:0]};
  assign wr_en       = cfg_valid && (cfg_wstrobe != 4'h0);
  assign ctrl_wr     = wr_en && (reg_sel == 3'd0) && cfg_wstrobe[0];
  assign busy        = (state != IDLE);
  assign hs          = m_valid && m_ready;
  assign start_go    = ctrl_wr && cfg_wdata[0] && !busy && (count != 32'd0);
  assign start_empty = ctrl_wr && cfg_wdata[0] && !busy && (count == 32'd0);
  assign done_set    = start_empty || (hs && (state_next == IDLE));
  assign done_clr    = wr_en && (reg_sel == 3'd1) && cfg_wstrobe[0] && cfg_wdata[1];
  assign cfg_ready   = 1'b1;
  assign irq         = done && irq_enable;

`ifdef VERDMA_ABORT_EN
  logic abort_pend;
  // An abort written in the same cycle as a handshake takes effect on that handshake.
  assign abort_hit = abort_pend || (ctrl_wr && cfg_wdata[2]);
  assign abort_rd  = abort_pend;
  always_ff @(posedge clk) begin
    if (reset)                              abort_pend <= 1'b0;
    else if (state_next == IDLE)            abort_pend <= 1'b0;
    else if (busy && ctrl_wr && cfg_wdata[2]) abort_pend <= 1'b1;
  end
`else
  assign abort_hit = 1'b0;
  assign abort_rd  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_go) state_next = READ;
      READ:    if (m_ready) state_next = abort_hit ? IDLE : WRITE;
      WRITE:   if (m_ready) state_next = ((count == 32'd1) || abort_hit) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_valid   = 1'b0;
    m_address = 32'd0;
    m_wstrobe = 4'h0;
    m_wdata   = 32'd0;
    case (state)
      READ: begin
        m_valid   = 1'b1;
        m_address = src;
      end
      WRITE: begin
        m_valid   = 1'b1;
        m_address = dst;
        m_wstrobe = 4'hF;
        m_wdata   = buffer;
      end
      default: ;
    endcase
  end

  // Address/count registers are frozen while busy so initiator outputs hold through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      src        <= 32'd0;
      dst        <= 32'd0;
      count      <= 32'd0;
      buffer     <= 32'd0;
      irq_enable <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (ctrl_wr) irq_enable <= cfg_wdata[1];
      if (!busy && wr_en) begin
        case (reg_sel)
          3'd2:    src   <= merge(src, cfg_wdata, cfg_wstrobe) & 32'hFFFF_FFFC;
          3'd3:    dst   <= merge(dst, cfg_wdata, cfg_wstrobe) & 32'hFFFF_FFFC;
          3'd4:    count <= merge(count, cfg_wdata, cfg_wstrobe);
          default: ;
        endcase
      end
      if ((state == READ) && m_ready) buffer <= m_rdata;
      if ((state == WRITE) && m_ready) begin
        src   <= src + 32'd4;
        dst   <= dst + 32'd4;
        count <= count - 32'd1;
      end
      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
    end
  end

  always_comb begin
    cfg_rdata = 32'd0;
    case (reg_sel)
      3'd0:    cfg_rdata = {29'd0, abort_rd, irq_enable, 1'b0};
      3'd1:    cfg_rdata = {30'd0, done, busy};
      3'd2:    cfg_rdata = src;
      3'd3:    cfg_rdata = dst;
      3'd4:    cfg_rdata = count;
      default: cfg_rdata = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_verdma.sv
// tb/tb_verdma.sv - randomized self-checking bench for verdma against a word-copy memory model
module tb_verdma;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [31:0] cfg_address;
  logic [3:0]  cfg_wstrobe;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_ready;
  logic        irq;
  logic        m_valid;
  logic [31:0] m_address;
  logic [3:0]  m_wstrobe;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  bit mon_en = 0;
  bit stalled = 0;
  int phase_cnt = 0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_strb;
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] hs_addr[$];
  logic [3:0]  hs_strb[$];

  verdma dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_address(cfg_address), .cfg_wstrobe(cfg_wstrobe),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_ready(cfg_ready), .irq(irq),
    .m_valid(m_valid), .m_address(m_address), .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Memory responder: picks m_ready for the coming edge, serves reads, records handshakes.
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      m_ready = 1'b0; stalled = 0; phase_cnt = 0;
    end else if (m_valid) begin
      if (stalled) begin
        check("hold_addr", m_address, h_addr);
        check("hold_strb", {28'd0, m_wstrobe}, {28'd0, h_strb});
        check("hold_data", m_wdata, h_data);
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (phase_cnt >= 3);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      phase_cnt++;
      m_rdata = mem_get(m_address);
      if (m_ready) begin
        hs_addr.push_back(m_address);
        hs_strb.push_back(m_wstrobe);
        if (m_wstrobe == 4'hF) mem[m_address] = m_wdata;
        phase_cnt = 0; stalled = 0;
      end else begin
        stalled = 1; h_addr = m_address; h_strb = m_wstrobe; h_data = m_wdata;
      end
    end else begin
      if (stalled) check("valid_hold", {31'd0, m_valid}, 32'd1);
      stalled = 0; phase_cnt = 0; m_ready = 1'b0;
      check("idle_bus", m_address | m_wdata | {28'd0, m_wstrobe}, 32'd0);
    end
  end

  task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_address = {27'd0, r, 2'b00}; cfg_wdata = d; cfg_wstrobe = s;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_wstrobe = 4'h0;
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] d);
    @(negedge clk);
    cfg_address = {$urandom_range(0, 7) == 0 ? 27'h7FF_FFFF : 27'd0, r, 2'b00};
    #1 d = cfg_rdata;
  endtask

  task automatic wait_irq(inout int cyc);
    while (!irq && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_irq", {31'd0, irq}, 32'd1);
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                          input int md, input bit meddle);
    logic [31:0] ea[$];
    logic [3:0]  es[$];
    logic [31:0] v;
    int cyc;
    mode = md;
    ref_mem = mem;
    hs_addr.delete(); hs_strb.delete();
    for (int i = 0; i < int'(n); i++) begin
      ea.push_back(s + 32'(4 * i)); es.push_back(4'h0);
      ref_mem[d + 32'(4 * i)] = ref_get(s + 32'(4 * i));
      ea.push_back(d + 32'(4 * i)); es.push_back(4'hF);
    end
    wr(3'd2, s); wr(3'd3, d); wr(3'd4, n); wr(3'd0, 32'h3);
    check("start_lat", {31'd0, m_valid}, 32'd1);
    cyc = 1;
    if (meddle) begin
      wr(3'd2, 32'hDEAD0); wr(3'd4, 32'd9); wr(3'd0, 32'h3);
      cyc += 6;
      rd(3'd1, v); cyc++;
      check("busy_flag", v, 32'h1);
    end
    wait_irq(cyc);
    if (md == 0 && !meddle) check("copy_cycles", 32'(cyc), 2 * n + 1);
    check("hs_count", 32'(hs_addr.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < hs_addr.size(); i++) begin
      check("hs_addr", hs_addr[i], ea[i]);
      check("hs_strb", {28'd0, hs_strb[i]}, {28'd0, es[i]});
    end
    for (int i = 0; i < int'(n); i++)
      check("mem_dst", mem_get(d + 32'(4 * i)), ref_get(d + 32'(4 * i)));
    rd(3'd4, v); check("end_count", v, 32'd0);
    rd(3'd2, v); check("end_src", v, s + 4 * n);
    rd(3'd3, v); check("end_dst", v, d + 4 * n);
    rd(3'd1, v); check("end_status", v, 32'h2);
    wr(3'd1, 32'h2);
    rd(3'd1, v); check("clr_status", v, 32'h0);
    check("clr_irq", {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int cyc;
    reset = 1'b1; cfg_valid = 1'b0; cfg_address = 32'd0; cfg_wstrobe = 4'h0; cfg_wdata = 32'd0;
    m_ready = 1'b0; m_rdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0; mon_en = 1;

    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    for (int r = 0; r < 8; r++) begin
      rd(3'(r), v); check("rst_reg", v, 32'd0);
    end

    run_copy(32'h100, 32'h200, 32'd3, 0, 0);
    run_copy(32'h100, 32'h200, 32'd3, 1, 0);

    // Zero-length start: done next cycle, no bus activity.
    mode = 0; hs_addr.delete();
    wr(3'd4, 32'd0); wr(3'd0, 32'h3);
    check("zero_irq", {31'd0, irq}, 32'd1);
    repeat (4) @(negedge clk);
    check("zero_hs", 32'(hs_addr.size()), 32'd0);
    rd(3'd1, v); check("zero_status", v, 32'h2);
    wr(3'd1, 32'h2);
    rd(3'd1, v); check("zero_clr", v, 32'h0);
    check("zero_irq_clr", {31'd0, irq}, 32'd0);

    run_copy(32'h300, 32'h500, 32'd4, 1, 1);
    run_copy(32'hFFFF_FFFC, 32'h600, 32'd2, 0, 0);

    wr(3'd2, 32'h103);
    rd(3'd2, v); check("src_align", v, 32'h100);
    wr(3'd2, 32'h1234_5678);
    wr(3'd2, 32'hAABB_CCDD, 4'b0101);
    rd(3'd2, v); check("src_lanes", v, 32'h12BB_56DC);
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, v); check("reg5_zero", v, 32'd0);
    rd(3'd0, v); check("ctrl_read", v, 32'h2);

`ifdef VERDMA_ABORT_EN
    mode = 1; hs_addr.delete(); hs_strb.delete();
    wr(3'd2, 32'h400); wr(3'd3, 32'h800); wr(3'd4, 32'd10); wr(3'd0, 32'h3);
    for (int i = 0; i < 400 && hs_addr.size() < 2; i++) @(negedge clk);
    wr(3'd0, 32'h6);
    cyc = 0;
    wait_irq(cyc);
    repeat (3) @(negedge clk);
    check("abort_hs", 32'(hs_addr.size()), 32'd3);
    rd(3'd4, v); check("abort_count", v, 32'd9);
    rd(3'd2, v); check("abort_src", v, 32'h404);
    rd(3'd1, v); check("abort_status", v, 32'h2);
    wr(3'd1, 32'h2);
`endif

    // Reset in the middle of a write phase.
    mode = 1;
    wr(3'd2, 32'h700); wr(3'd3, 32'h900); wr(3'd4, 32'd5); wr(3'd0, 32'h3);
    cyc = 0;
    while (!(m_valid && m_wstrobe == 4'hF) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_write", {31'd0, m_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 5; r++) begin
      rd(3'(r), v); check("rst_mid_reg", v, 32'd0);
    end
    check("rst_mid_irq", {31'd0, irq}, 32'd0);

    for (int t = 0; t < 8; t++) begin
      logic [31:0] s, d, n;
      s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                      : ($urandom & 32'hFFFF_FFFC);
      d = ($urandom_range(0, 3) == 0) ? (s + 32'($urandom_range(1, 3) * 4))
                                      : ($urandom & 32'hFFFF_FFFC);
      n = 32'($urandom_range(1, 6));
      run_copy(s, d, n, $urandom_range(0, 2), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
